uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
//
// PURPOSE
//   Parametrised serial character receiver; successor to the fixed 8-bit receiver.
//   - Oversamples i_rx at CLKS_PER_BIT clocks per bit.
//   - Configurable data width, optional parity and 1 or 2 stop bits.
//   - Flags framing and parity errors; start-bit glitches are rejected.
//   - Delivers each character on a valid/ready handshake with a one-entry holding buffer and overrun detection.
//   - Sits between the serial pin and the character consumer (command parser / FIFO).
//
// PARAMETERS
//   CLKS_PER_BIT  16  clocks per bit; >=4, even
//   DATA_BITS     8   data bits per frame, 5..9, LSB first
//   PARITY_EN     0   1 = parity bit follows data
//   PARITY_ODD    0   1 = odd parity, 0 = even (used only when PARITY_EN=1)
//   STOP_BITS     1   1 or 2
//
// PORTS
//   i_clk         in   1          clock
//   i_rst         in   1          asynchronous reset, active-high
//   i_rx          in   1          serial line, idle high, asynchronous to i_clk
//   o_data        out  DATA_BITS  received character
//   o_valid       out  1          o_data/o_parity_err/o_frame_err valid
//   i_ready       in   1          consumer accepts; transfer when o_valid & i_ready
//   o_parity_err  out  1          parity mismatch for the presented character
//   o_frame_err   out  1          a stop bit sampled 0 for the presented character
//   o_overrun     out  1          1-cycle pulse: completed frame dropped, buffer full
//   o_busy        out  1          1 while state != IDLE
//
// BEHAVIOUR
//   Reset
//   - Asynchronous on i_rst=1. State=IDLE, counters=0, synchroniser=2'b11.
//   - All outputs 0. Reset mid-frame abandons the frame; nothing is presented.
//
//   Input sampling
//   - i_rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE: rx_s==0 -> START, bit counter clk_cnt=0.
//   - START: at clk_cnt==CLKS_PER_BIT/2-1, sample rx_s.
//     - 1 -> IDLE (glitch, no output).
//     - 0 -> DATA, clk_cnt=0.
//   - DATA/PARITY/STOP: sample rx_s when clk_cnt==CLKS_PER_BIT-1 (bit centre), then clk_cnt=0.
//     - DATA: shift rx_s into the shift register MSB side; after DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
//     - PARITY: perr = rx_s ^ (^shift) ^ PARITY_ODD; -> STOP.
//     - STOP: any stop sample 0 sets ferr; after STOP_BITS samples the frame completes and the FSM returns to IDLE at once (mid-stop), so a back-to-back start bit is caught.
//   - perr=0 when PARITY_EN=0.
//
//   Output buffer
//   - Frame completes in cycle t -> o_data/o_parity_err/o_frame_err loaded and o_valid=1 at t+1.
//   - Frame data is delivered even when ferr/perr are set.
//   - o_valid holds, and outputs stay stable, until the cycle o_valid & i_ready; o_valid drops the next cycle.
//   - Completion while o_valid & !i_ready: new frame discarded, held data unchanged, o_overrun=1 for 1 cycle.
//   - Completion in the same cycle as a transfer: new frame loaded, o_valid stays 1, no overrun.
//
//   Other
//   - clk_cnt width = $clog2(CLKS_PER_BIT); bit counter width = $clog2(DATA_BITS+1).
//   - Sample-to-output latency: 1 clock after the final stop-bit sample.
//
// TESTING  (CLKS_PER_BIT=16, DATA_BITS=8 unless stated)
//   1. Send 0xA5, 8N1, i_ready=1.
//      -> one o_valid pulse, o_data=0xA5, both err=0, o_overrun=0.
//   2. PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1.
//      -> o_data=0x03, o_parity_err=1. Resend with parity 0 -> o_parity_err=0.
//   3. Send 0x5A with stop bit forced 0.
//      -> o_data=0x5A, o_frame_err=1.
//      STOP_BITS=2 with second stop bit 0 -> o_frame_err=1.
//   4. i_ready=0, send 0x11 then 0x22 back-to-back.
//      -> o_data stays 0x11, o_overrun pulses once.
//      Raise i_ready -> 0x11 transferred, o_valid=0 next cycle.
//   5. Pull i_rx low for 5 clocks in IDLE.
//      -> returns to IDLE, no o_valid.
//      Assert i_rst mid-DATA -> all outputs 0, next clean 0x3C frame received correctly.
//   6. Two frames back-to-back, i_ready tied 1.
//      -> both delivered in order.
//      Frame completing in the same cycle as a transfer -> o_valid stays 1, no overrun.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling serial receiver with parity/stop checks and a one-entry valid/ready output buffer
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic rx_meta, rx_s, perr, ferr, half, full, done, held;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shift;
    assign half = clk_cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign full = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign held = o_valid && !i_ready;
    assign o_busy = state != IDLE;
    always_comb begin
        state_n = state;
        done = 1'b0;
        case (state)
            IDLE:   state_n = rx_s ? IDLE : START;
            START:  state_n = half ? (rx_s ? IDLE : DATA) : START;
            DATA:   state_n = (full && bit_cnt == BW'(DATA_BITS - 1)) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
            PARITY: state_n = full ? STOP : PARITY;
            STOP: begin
                done = full && bit_cnt == BW'(STOP_BITS - 1);
                state_n = done ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            state   <= state_n;
            clk_cnt <= (state == IDLE || state_n != state || full) ? '0 : clk_cnt + 1'b1;
            bit_cnt <= (state_n != state) ? '0 : (full ? bit_cnt + 1'b1 : bit_cnt);
            if (state == START) begin
                perr <= 1'b0;
                ferr <= 1'b0;
            end
            if (state == DATA && full) shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (state == PARITY && full) perr <= rx_s ^ (^shift) ^ 1'(PARITY_ODD);
            if (state == STOP && full && !rx_s) ferr <= 1'b1;
        end
    end
    // the final stop sample is folded in directly since ferr only updates after it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= done && held;
            if (done && !held) begin
                o_data       <= shift;
                o_parity_err <= perr;
                o_frame_err  <= ferr | ~rx_s;
                o_valid      <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame across 8N1, even-parity and two-stop-bit instances
module tb_uart_rx_frame;
    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] rx = 3'b111, rdy = 3'b111;
    logic [7:0] d0, d1, d2;
    logic v0, v1, v2, p0, p1, p2, f0, f1, f2, o0, o1, o2, b0, b1, b2;
    int checks = 0, passed = 0, ovr0 = 0;
    logic [7:0] qd0[$], qd1[$], qd2[$];
    logic qp0[$], qp1[$], qp2[$], qf0[$], qf1[$], qf2[$];

    always #5 clk = ~clk;

    uart_rx_frame u_8n1 (.i_clk(clk), .i_rst(rst), .i_rx(rx[0]), .o_data(d0), .o_valid(v0), .i_ready(rdy[0]),
                         .o_parity_err(p0), .o_frame_err(f0), .o_overrun(o0), .o_busy(b0));
    uart_rx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (.i_clk(clk), .i_rst(rst), .i_rx(rx[1]), .o_data(d1), .o_valid(v1),
                         .i_ready(rdy[1]), .o_parity_err(p1), .o_frame_err(f1), .o_overrun(o1), .o_busy(b1));
    uart_rx_frame #(.STOP_BITS(2)) u_s2 (.i_clk(clk), .i_rst(rst), .i_rx(rx[2]), .o_data(d2), .o_valid(v2), .i_ready(rdy[2]),
                         .o_parity_err(p2), .o_frame_err(f2), .o_overrun(o2), .o_busy(b2));

    always @(negedge clk) begin
        if (v0 && rdy[0]) begin qd0.push_back(d0); qp0.push_back(p0); qf0.push_back(f0); end
        if (v1 && rdy[1]) begin qd1.push_back(d1); qp1.push_back(p1); qf1.push_back(f1); end
        if (v2 && rdy[2]) begin qd2.push_back(d2); qp2.push_back(p2); qf2.push_back(f2); end
        if (o0) ovr0++;
    end

    task automatic send(input int idx, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx[idx] = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx[idx] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        qd0.delete(); qp0.delete(); qf0.delete();
        qd1.delete(); qp1.delete(); qf1.delete();
        qd2.delete(); qp2.delete(); qf2.delete();
        ovr0 = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (d0 !== 8'h00) $display("FAIL rst_data got %h exp 00", d0); else passed++;
        checks++; if (v0 !== 1'b0) $display("FAIL rst_valid got %b exp 0", v0); else passed++;
        checks++; if (p0 !== 1'b0 || f0 !== 1'b0) $display("FAIL rst_err got %b%b exp 00", p0, f0); else passed++;
        checks++; if (o0 !== 1'b0 || b0 !== 1'b0) $display("FAIL rst_ovr_busy got %b%b exp 00", o0, b0); else passed++;
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_8n1();
        clear();
        rdy[0] = 1'b1;
        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
        idle(20);
        checks++; if (qd0.size() !== 1) $display("FAIL a5_count got %0d exp 1", qd0.size()); else passed++;
        checks++; if (qd0[0] !== 8'hA5) $display("FAIL a5_data got %h exp a5", qd0[0]); else passed++;
        checks++; if (qp0[0] !== 1'b0 || qf0[0] !== 1'b0) $display("FAIL a5_err got %b%b exp 00", qp0[0], qf0[0]); else passed++;
        checks++; if (ovr0 !== 0) $display("FAIL a5_overrun got %0d exp 0", ovr0); else passed++;
    endtask

    task automatic test_parity();
        clear();
        send(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
        idle(20);
        send(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
        idle(20);
        checks++; if (qd1.size() !== 2) $display("FAIL par_count got %0d exp 2", qd1.size()); else passed++;
        checks++; if (qd1[0] !== 8'h03 || qp1[0] !== 1'b1) $display("FAIL par_bad got %h/%b exp 03/1", qd1[0], qp1[0]); else passed++;
        checks++; if (qd1[1] !== 8'h03 || qp1[1] !== 1'b0) $display("FAIL par_good got %h/%b exp 03/0", qd1[1], qp1[1]); else passed++;
        checks++; if (qf1[0] !== 1'b0 || qf1[1] !== 1'b0) $display("FAIL par_ferr got %b%b exp 00", qf1[0], qf1[1]); else passed++;
    endtask

    task automatic test_frame_err();
        clear();
        send(0, 16'({1'b0, 8'h5A, 1'b0}), 10);
        idle(20);
        checks++; if (qd0.size() !== 1) $display("FAIL ferr_count got %0d exp 1", qd0.size()); else passed++;
        checks++; if (qd0[0] !== 8'h5A || qf0[0] !== 1'b1) $display("FAIL ferr_1stop got %h/%b exp 5a/1", qd0[0], qf0[0]); else passed++;
        checks++; if (qp0[0] !== 1'b0) $display("FAIL ferr_perr got %b exp 0", qp0[0]); else passed++;
        send(2, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11);
        idle(20);
        send(2, 16'({1'b0, 1'b1, 8'h5A, 1'b0}), 11);
        idle(20);
        checks++; if (qd2.size() !== 2) $display("FAIL s2_count got %0d exp 2", qd2.size()); else passed++;
        checks++; if (qf2[0] !== 1'b0) $display("FAIL s2_clean_ferr got %b exp 0", qf2[0]); else passed++;
        checks++; if (qd2[1] !== 8'h5A || qf2[1] !== 1'b1) $display("FAIL s2_bad_stop got %h/%b exp 5a/1", qd2[1], qf2[1]); else passed++;
    endtask

    task automatic test_overrun();
        clear();
        rdy[0] = 1'b0;
        send(0, 16'({1'b1, 8'h11, 1'b0}), 10);
        send(0, 16'({1'b1, 8'h22, 1'b0}), 10);
        idle(20);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h11) $display("FAIL ovr_hold got %b/%h exp 1/11", v0, d0); else passed++;
        checks++; if (ovr0 !== 1) $display("FAIL ovr_pulses got %0d exp 1", ovr0); else passed++;
        checks++; if (qd0.size() !== 0) $display("FAIL ovr_no_xfer got %0d exp 0", qd0.size()); else passed++;
        rdy[0] = 1'b1;
        idle(1);
        checks++; if (v0 !== 1'b0) $display("FAIL ovr_drop got %b exp 0", v0); else passed++;
        checks++; if (qd0.size() !== 1 || qd0[0] !== 8'h11) $display("FAIL ovr_xfer got %0d/%h exp 1/11", qd0.size(), qd0[0]); else passed++;
    endtask

    task automatic test_glitch_reset();
        clear();
        rx[0] = 1'b0;
        idle(5);
        checks++; if (b0 !== 1'b1) $display("FAIL glitch_busy got %b exp 1", b0); else passed++;
        rx[0] = 1'b1;
        idle(20);
        checks++; if (b0 !== 1'b0 || v0 !== 1'b0) $display("FAIL glitch_idle got %b%b exp 00", b0, v0); else passed++;
        checks++; if (qd0.size() !== 0) $display("FAIL glitch_xfer got %0d exp 0", qd0.size()); else passed++;
        rdy[0] = 1'b0;
        send(0, 16'({1'b1, 8'h44, 1'b0}), 10);
        idle(20);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h44) $display("FAIL rst_pre got %b/%h exp 1/44", v0, d0); else passed++;
        rx[0] = 1'b0;
        idle(60);
        checks++; if (b0 !== 1'b1) $display("FAIL rst_mid_busy got %b exp 1", b0); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (v0 !== 1'b0 || d0 !== 8'h00) $display("FAIL rst_mid_out got %b/%h exp 0/00", v0, d0); else passed++;
        checks++; if (b0 !== 1'b0 || p0 !== 1'b0 || f0 !== 1'b0 || o0 !== 1'b0) $display("FAIL rst_mid_flags got %b%b%b%b exp 0000", b0, p0, f0, o0); else passed++;
        rx[0] = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(5);
        clear();
        rdy[0] = 1'b1;
        send(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
        idle(20);
        checks++; if (qd0.size() !== 1 || qd0[0] !== 8'h3C) $display("FAIL rst_after got %0d/%h exp 1/3c", qd0.size(), qd0[0]); else passed++;
        checks++; if (qf0[0] !== 1'b0 || qp0[0] !== 1'b0) $display("FAIL rst_after_err got %b%b exp 00", qf0[0], qp0[0]); else passed++;
    endtask

    task automatic test_back_to_back();
        clear();
        rdy[0] = 1'b1;
        send(0, 16'({1'b1, 8'h81, 1'b0}), 10);
        send(0, 16'({1'b1, 8'h7E, 1'b0}), 10);
        idle(20);
        checks++; if (qd0.size() !== 2) $display("FAIL b2b_count got %0d exp 2", qd0.size()); else passed++;
        checks++; if (qd0[0] !== 8'h81 || qd0[1] !== 8'h7E) $display("FAIL b2b_order got %h,%h exp 81,7e", qd0[0], qd0[1]); else passed++;
        checks++; if (ovr0 !== 0) $display("FAIL b2b_overrun got %0d exp 0", ovr0); else passed++;
        clear();
        rdy[0] = 1'b0;
        send(0, 16'({1'b1, 8'hC3, 1'b0}), 10);
        idle(20);
        // final stop sample lands on the 155th edge after the start bit is driven
        fork
            send(0, 16'({1'b1, 8'h96, 1'b0}), 10);
            begin
                repeat (154) @(posedge clk);
                #1;
                rdy[0] = 1'b1;
                idle(1);
                checks++; if (v0 !== 1'b1 || d0 !== 8'h96) $display("FAIL same_cycle got %b/%h exp 1/96", v0, d0); else passed++;
                rdy[0] = 1'b0;
            end
        join
        idle(20);
        checks++; if (qd0.size() !== 1 || qd0[0] !== 8'hC3) $display("FAIL same_first got %0d/%h exp 1/c3", qd0.size(), qd0[0]); else passed++;
        checks++; if (ovr0 !== 0 || v0 !== 1'b1) $display("FAIL same_ovr got %0d/%b exp 0/1", ovr0, v0); else passed++;
        rdy[0] = 1'b1;
        idle(3);
        checks++; if (qd0.size() !== 2 || qd0[1] !== 8'h96) $display("FAIL same_second got %0d/%h exp 2/96", qd0.size(), qd0[1]); else passed++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
